// File: rtl/apb_slave_mem.sv
// APB4 completer fronting a small word-addressed register memory; optional PPROT checks under APB_SLV_PROT_CHECK_EN.
// Latency: 2+WAIT_STATES cycles from setup phase to PREADY; back-to-back setups accepted with no dead cycle.
// Backpressure: PREADY held low for WAIT_STATES access cycles; dropping PSEL mid-access aborts with no memory update.
module apb_slave_mem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int                    MEM_DEPTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,      // active-high despite the name
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_WIDTH-1:0] PSTRB,
    input  logic [2:0]            PPROT,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int                    LSB     = $clog2(STRB_WIDTH);
    localparam int                    IDX_W   = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [3:0]            WS      = 4'(WAIT_STATES);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Reset asserts immediately but releases two clocks later, synchronously.
    logic rst_meta_q;
    logic rst_sync_q;

    // Release synchronizer for the asynchronous reset input.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Setup-phase address decode.
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word_off;
    logic [IDX_W-1:0]      setup_idx;
    logic                  dec_err;
    logic                  prot_err;
    logic                  setup_err;
    logic                  unused_prot;

    assign offset    = PADDR - BASE_ADDR;
    assign word_off  = offset >> LSB;
    assign setup_idx = word_off[IDX_W-1:0];
    assign dec_err   = (PADDR < BASE_ADDR) || (word_off >= DEPTH_A) || (PADDR[LSB-1:0] != '0);
    assign unused_prot = ^PPROT;

`ifdef APB_SLV_PROT_CHECK_EN
    // Unprivileged writes and non-secure accesses to the upper half are refused.
    assign prot_err = (PWRITE && !PPROT[0]) || (PPROT[1] && setup_idx[IDX_W-1]);
`else
    assign prot_err = 1'b0;
`endif

    assign setup_err = dec_err || prot_err;

    // Completion happens in the access cycle where the wait counter has run out.
    logic xfer_done;
    assign xfer_done = (state_q == ST_ACCESS) && PSEL && (cnt_q == 4'd0);

    // Next-state logic: capture on setup, count wait states, leave on completion or abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        err_d   = err_q;
        if (state_q == ST_IDLE) begin
            if (PSEL && !PENABLE) begin
                idx_d   = setup_idx;
                wr_d    = PWRITE;
                err_d   = setup_err;
                cnt_d   = WS;
                state_d = ST_ACCESS;
            end
        end else begin
            if (!PSEL) begin
                state_d = ST_IDLE;
            end else if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    // Storage: cleared on reset, byte-lane writes on an error-free write completion.
    always_ff @(posedge clk or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            for (int w = 0; w < MEM_DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else if (xfer_done && wr_q && !err_q) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (PSTRB[b]) begin
                    mem_q[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
                end
            end
        end
    end

    // Response outputs are zero everywhere except the completing cycle.
    assign PREADY  = xfer_done;
    assign PSLVERR = xfer_done && err_q;
    assign PRDATA  = (xfer_done && !wr_q && !err_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: two completers (1 and 0 wait states) on a shared bus, each with its own PSEL.
// Latency: checks 2+WAIT_STATES setup-to-ready cycles and back-to-back acceptance.
// Backpressure: covers wait states, PSEL abort and reset during an access.
module tb_apb_slave_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel_a = 1'b0;
    logic        psel_b = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic        ready_a, ready_b, slverr_a, slverr_b;
    logic [31:0] rdata_a, rdata_b;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    apb_slave_mem #(.WAIT_STATES(1)) u_a (
        .clk(clk), .rst_n(rst), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PREADY(ready_a), .PRDATA(rdata_a), .PSLVERR(slverr_a)
    );

    apb_slave_mem #(.WAIT_STATES(0)) u_b (
        .clk(clk), .rst_n(rst), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PREADY(ready_b), .PRDATA(rdata_b), .PSLVERR(slverr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One APB transfer; starts at posedge+1, returns at posedge+1 with the bus idle.
    task automatic xfer(input bit sel, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                        output logic [31:0] rd, output logic err, output int ncyc);
        logic rdy;
        psel_a  = !sel;
        psel_b  = sel;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = prot;
        @(posedge clk); #1;
        penable = 1'b1;
        ncyc = 1;
        #1;
        rdy = sel ? ready_b : ready_a;
        while (!rdy && ncyc < 40) begin
            @(posedge clk); #2;
            ncyc++;
            rdy = sel ? ready_b : ready_a;
        end
        if (!rdy) check("ready_timeout", 32'(rdy), 32'd1);
        rd  = sel ? rdata_b : rdata_a;
        err = sel ? slverr_b : slverr_a;
        @(posedge clk); #1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
    endtask

    task automatic wait_release();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        err;
    int          n;

    initial begin
        // Reset state
        #3;
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_slverr_a", 32'(slverr_a), 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd0);
        wait_release();

        // Read of cleared memory, one wait state
        xfer(0, 0, 32'h0, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("rd0_data", rd, 32'h0);
        check("rd0_err", 32'(err), 32'd0);
        check("rd0_cycles", 32'(n), 32'd2);

        // Byte strobes
        xfer(0, 1, 32'h8, 32'hDEADBEEF, 4'hF, 3'b001, rd, err, n);
        check("wr8_err", 32'(err), 32'd0);
        check("wr8_cycles", 32'(n), 32'd2);
        xfer(0, 1, 32'h8, 32'h11223344, 4'b0101, 3'b001, rd, err, n);
        xfer(0, 0, 32'h8, 32'h0, 4'h0, 3'b001, rd, err, n);
        check("strb_merge", rd, 32'hDE22BE44);
        xfer(0, 1, 32'h8, 32'hFFFFFFFF, 4'h0, 3'b001, rd, err, n);
        check("strb0_err", 32'(err), 32'd0);
        xfer(0, 0, 32'h8, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("strb0_nochange", rd, 32'hDE22BE44);

        // Zero wait states, back-to-back
        xfer(1, 1, 32'h0, 32'hCAFEF00D, 4'hF, 3'b001, rd, err, n);
        check("b2b_wr0_cycles", 32'(n), 32'd1);
        xfer(1, 1, 32'h4, 32'h01020304, 4'hF, 3'b001, rd, err, n);
        check("b2b_wr4_cycles", 32'(n), 32'd1);
        xfer(1, 0, 32'h4, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("b2b_rd4_data", rd, 32'h01020304);
        check("b2b_rd4_cycles", 32'(n), 32'd1);
        xfer(1, 0, 32'h0, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("b2b_rd0_data", rd, 32'hCAFEF00D);

        // Last word and decode errors
        xfer(0, 1, 32'h3C, 32'h5A5A5A5A, 4'hF, 3'b001, rd, err, n);
        check("last_wr_err", 32'(err), 32'd0);
        xfer(0, 0, 32'h3C, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("last_rd_data", rd, 32'h5A5A5A5A);
        xfer(0, 0, 32'h40, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("oob_rd_err", 32'(err), 32'd1);
        check("oob_rd_data", rd, 32'h0);
        xfer(0, 1, 32'h2, 32'hFFFFFFFF, 4'hF, 3'b001, rd, err, n);
        check("mis_wr_err", 32'(err), 32'd1);
        xfer(0, 0, 32'h3E, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("mis_rd_err", 32'(err), 32'd1);
        check("mis_rd_data", rd, 32'h0);
        xfer(0, 0, 32'h0, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("after_err_rd0", rd, 32'h0);
        check("after_err_rd0_err", 32'(err), 32'd0);

        // PSEL dropped mid-access: no write
        psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'hAAAAAAAA; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check("abort_wait_ready", 32'(ready_a), 32'd0);
        @(posedge clk); #1;
        psel_a = 1'b0; penable = 1'b0;
        #1;
        check("abort_ready", 32'(ready_a), 32'd0);
        @(posedge clk); #1;
        xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("abort_rd", rd, 32'h0);

        // Reset during access
        xfer(1, 1, 32'hC, 32'h77777777, 4'hF, 3'b001, rd, err, n);
        xfer(1, 0, 32'hC, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("pre_rst_rdC", rd, 32'h77777777);
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'hC; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check("mid_rst_ready_before", 32'(ready_b), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready_after", 32'(ready_b), 32'd0);
        @(posedge clk); #1;
        psel_b = 1'b0; penable = 1'b0;
        @(posedge clk);
        wait_release();
        xfer(1, 0, 32'hC, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("post_rst_rdC", rd, 32'h0);
        xfer(0, 0, 32'h8, 32'h0, 4'hF, 3'b001, rd, err, n);
        check("post_rst_rd8", rd, 32'h0);

        // Protection
`ifdef APB_SLV_PROT_CHECK_EN
        xfer(0, 1, 32'h4, 32'h12345678, 4'hF, 3'b000, rd, err, n);
        check("prot_unpriv_err", 32'(err), 32'd1);
        xfer(0, 0, 32'h4, 32'h0, 4'hF, 3'b000, rd, err, n);
        check("prot_unpriv_rd", rd, 32'h0);
        xfer(0, 1, 32'h4, 32'h12345678, 4'hF, 3'b001, rd, err, n);
        check("prot_priv_err", 32'(err), 32'd0);
        xfer(0, 0, 32'h4, 32'h0, 4'hF, 3'b000, rd, err, n);
        check("prot_priv_rd", rd, 32'h12345678);
        xfer(0, 1, 32'h20, 32'h0BADF00D, 4'hF, 3'b011, rd, err, n);
        check("prot_ns_err", 32'(err), 32'd1);
        xfer(0, 0, 32'h20, 32'h0, 4'hF, 3'b000, rd, err, n);
        check("prot_ns_rd", rd, 32'h0);
`else
        xfer(0, 1, 32'h4, 32'h12345678, 4'hF, 3'b000, rd, err, n);
        check("noprot_unpriv_err", 32'(err), 32'd0);
        xfer(0, 0, 32'h4, 32'h0, 4'hF, 3'b000, rd, err, n);
        check("noprot_unpriv_rd", rd, 32'h12345678);
        xfer(0, 1, 32'h20, 32'h0BADF00D, 4'hF, 3'b010, rd, err, n);
        check("noprot_ns_err", 32'(err), 32'd0);
        xfer(0, 0, 32'h20, 32'h0, 4'hF, 3'b010, rd, err, n);
        check("noprot_ns_rd", rd, 32'h0BADF00D);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end

endmodule
